fft_result_reader: RTL and testbench
====================================

# fft_result_reader

Read-out engine for the radix-2 FFT core. When the FFT raises its one-cycle `finish` pulse, this block walks the ping-pong bank that holds the last-stage results through a one-cycle-latency synchronous read port. It streams the N complex bins out on a valid/ready interface in natural bin order, with optional bit-reversal applied to the RAM address. It is the consumer-side counterpart of the FFT memory writer and owns the read port of the result bank for the whole time it is busy.

## Interface
- `N`, 8: FFT length; power of two, at least 4. LOG2N = $clog2(N).
- `DATA_WIDTH`, 16: width of each of re and im, two's complement.
- `BITREV`, 0: 1 = RAM address is the bit-reverse of the bin index; 0 = address equals the bin index.
- `FIFO_DEPTH`, 4: depth of the internal skid FIFO; at least 3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `finish`  in  1  one-cycle pulse from the FFT: results are complete.
- `bank_sel`  out  LOG2N-independent, 1 bit  bank holding the results: 1 = mem1, 0 = mem0. Constant value ((LOG2N-1) even) ? 1 : 0.
- `rd_en`  out  1  read strobe to the result bank.
- `rd_addr`  out  LOG2N  read address.
- `rd_data`  in  2*DATA_WIDTH  {re, im}, re in the upper half. Valid the cycle after `rd_en`.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_re`, `out_im`  out  DATA_WIDTH each  bin value.
- `out_index`  out  LOG2N  bin index k; always natural order.
- `out_last`  out  1  high with bin N-1.
- `busy`  out  1  high from the cycle after `finish` until `done`.
- `done`  out  1  one-cycle pulse after the last handshake.

## Operation
- FSM states:
  - IDLE: waits for `finish`; goes to STREAM.
  - STREAM: issues reads; goes to DRAIN after issuing address N-1.
  - DRAIN: no more reads; returns to IDLE on the handshake of bin N-1, and pulses `done` in the following cycle.
- Read issue:
  - Issue counter `rk` runs 0..N-1.
  - `rd_en` = STREAM && (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - `rd_addr` = BITREV ? bitrev(rk) : rk.
  - `rk` increments on each `rd_en`.
- Capture: a registered flag marks each read in flight. `rd_data` is pushed into the FIFO together with its index one cycle after `rd_en`.
- The FIFO can never overflow, because reads are credit-limited.
- Output:
  - The FIFO head drives `out_*` registers.
  - A handshake occurs when `out_valid && out_ready`.
  - While `out_valid && !out_ready`, all `out_*` values hold stable.
  - `out_valid` never drops without a handshake.
- Data is passed through unchanged. There is no scaling, rounding or sign manipulation.
- `finish` in STREAM or DRAIN is ignored; there is no restart and no error.
- `finish` arriving in the same cycle as `done` is accepted, and a new pass begins.
- Asynchronous reset mid-pass:
  - FIFO, counters and in-flight flag clear, and the FSM returns to IDLE.
  - No `done` pulse is produced for the aborted pass.
- Reset values: `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_re`=0, `out_im`=0, `out_index`=0, `out_last`=0, `busy`=0, `done`=0.

## Timing
- `finish` high in cycle c:
  - `busy` and `rd_en` (address for k=0) are high in cycle c+1.
  - `rd_data` is valid in c+2 and captured at the end of c+2.
  - `out_valid` is high in c+3.
- With `out_ready` held at 1: one bin per cycle, bin k in cycle c+3+k, `out_last` in c+N+2, `done` in c+N+3, `busy` low from c+N+3.
- With `out_ready` low: reads stop once FIFO_DEPTH entries are held or in flight. When ready returns, output resumes at the next cycle with no bubble, since the FIFO is non-empty.
- Minimum gap from `done` to accepting the next `finish`: 0 cycles.

## Test plan
- N=8, BITREV=0, RAM preloaded with word k = {re=k, im=-k}, `finish` pulse, `out_ready`=1:
  - out_valid is high in cycles c+3..c+10, with out_re 0..7, out_im 0,-1..-7 and out_index 0..7.
  - out_last is high only at c+10, done at c+11, and there are exactly 8 `rd_en` pulses.
- N=8, BITREV=1, same preload:
  - rd_addr sequence is 0,4,2,6,1,5,3,7.
  - out_re sequence is 0,4,2,6,1,5,3,7, with out_index 0..7.
- Backpressure: `out_ready` toggles 1,0,0,1 repeating.
  - All 8 bins arrive in order with no loss or duplication, and out_* are stable across stalls.
  - FIFO occupancy plus in-flight reads never exceeds 4.
- `finish` pulse in cycle c+5 while busy: ignored; a single pass of 8 bins and one done pulse.
- `rst_n` asserted at c+6 with 3 bins delivered:
  - All outputs are at reset values immediately, without waiting for a clock edge.
  - No done pulse; a later `finish` restarts cleanly from bin 0.
- `bank_sel`: N=8 gives 1, N=16 gives 0, N=4 gives 0.

Source files
------------

// File: rtl/fft_result_reader_if.sv
// Output stream of fft_result_reader: one complex FFT bin per valid/ready handshake.
interface fft_result_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 3
) ();
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_re;
  logic signed [DATA_WIDTH-1:0] out_im;
  logic        [IDX_W-1:0]      out_index;
  logic                         out_last;

  modport master (output out_valid, out_re, out_im, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_re, out_im, out_index, out_last, output out_ready);
endinterface

// File: rtl/fft_result_reader.sv
// Streams the N result bins of the FFT out of the result bank in natural order,
// credit-limited reads through a 1-cycle-latency RAM port into a small skid FIFO.
module fft_result_reader #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BITREV     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    finish,
  output logic                    bank_sel,
  output logic                    rd_en,
  output logic [$clog2(N)-1:0]    rd_addr,
  input  logic [2*DATA_WIDTH-1:0] rd_data,
  fft_result_reader_if.master     out_if,
  output logic                    busy,
  output logic                    done
);

  localparam int LOG2N = $clog2(N);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = LOG2N + 2*DATA_WIDTH;
  localparam logic [LOG2N-1:0] LAST_K = LOG2N'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_e;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_e                       state_q, state_d;
  logic [LOG2N-1:0]             rk_q, rk_d, cap_idx_q;
  logic                         inflight_q;
  logic [ENT_W-1:0]             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic signed [DATA_WIDTH-1:0] out_re_q, out_re_d, out_im_q, out_im_d;
  logic [LOG2N-1:0]             out_index_q, out_index_d;
  logic                         done_q, done_d;
  logic [CNT_W:0]               credit_used;
  logic                         hs, push, pop, load;
  logic [ENT_W-1:0]             cap_word, load_word;

  // The output register counts as a FIFO slot, so the credit check covers it too.
  assign credit_used = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(out_valid_q) + (CNT_W+1)'(inflight_q);
  assign hs          = out_valid_q && out_if.out_ready;
  assign cap_word    = {cap_idx_q, rd_data};
  assign done_d      = (state_q == S_DRAIN) && hs && out_last_q;
  assign rk_d        = rd_en ? rk_q + LOG2N'(1) : rk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (finish) state_d = S_STREAM;
      S_STREAM: if (rd_en && rk_q == LAST_K) state_d = S_DRAIN;
      S_DRAIN:  if (hs && out_last_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    rd_en = (state_q == S_STREAM) && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  end

  // Refill the output register from the FIFO head, or straight from the RAM
  // when the FIFO is empty, so the first bin appears without an extra bubble.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    load        = 1'b0;
    load_word   = fifo_mem_q[rd_ptr_q];
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    if (!out_valid_q || hs) begin
      if (cnt_q != '0) begin
        load = 1'b1;
        pop  = 1'b1;
        push = inflight_q;
      end else if (inflight_q) begin
        load      = 1'b1;
        load_word = cap_word;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      push = inflight_q;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_index_d = load_word[ENT_W-1 -: LOG2N];
      out_re_d    = $signed(load_word[2*DATA_WIDTH-1 -: DATA_WIDTH]);
      out_im_d    = $signed(load_word[DATA_WIDTH-1:0]);
      out_last_d  = (load_word[ENT_W-1 -: LOG2N] == LAST_K);
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_q        <= '0;
      cap_idx_q   <= '0;
      inflight_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rk_q        <= rk_d;
      cap_idx_q   <= rk_q;
      inflight_q  <= rd_en;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= cap_word;
  end

  // The last butterfly stage lands in mem1 when LOG2N-1 is even.
  assign bank_sel         = ((LOG2N - 1) % 2 == 0) ? 1'b1 : 1'b0;
  assign rd_addr          = (BITREV != 0) ? bitrev(rk_q) : rk_q;
  assign done             = done_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_re    = out_re_q;
  assign out_if.out_im    = out_im_q;
  assign out_if.out_index = out_index_q;
  assign out_if.out_last  = out_last_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: two N=8 readers (BITREV 0/1) fed from one RAM image.
module tb_fft_result_reader;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int FD = 4;

  logic clk = 1'b0, rst_n = 1'b0, finish = 1'b0, out_ready = 1'b1;
  int   cyc = 0;
  int   rdy_mode = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        bank_sel0, rd_en0, busy0, done0, bank_sel1, rd_en1, busy1, done1;
  logic [2:0]  rd_addr0, rd_addr1;
  logic [31:0] rd_data0, rd_data1;
  logic        bs16, rden16, busy16, done16, bs4, rden4, busy4, done4;
  logic [3:0]  addr16;
  logic [1:0]  addr4;
  logic [31:0] ram [N];
  int          br_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_result_reader_if #(.DATA_WIDTH(DW), .IDX_W(3)) if0 ();
  fft_result_reader_if #(.DATA_WIDTH(DW), .IDX_W(3)) if1 ();
  fft_result_reader_if #(.DATA_WIDTH(DW), .IDX_W(4)) if16 ();
  fft_result_reader_if #(.DATA_WIDTH(DW), .IDX_W(2)) if4 ();
  assign if0.out_ready  = out_ready;
  assign if1.out_ready  = out_ready;
  assign if16.out_ready = 1'b1;
  assign if4.out_ready  = 1'b1;

  fft_result_reader #(.N(N), .DATA_WIDTH(DW), .BITREV(0), .FIFO_DEPTH(FD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .finish(finish), .bank_sel(bank_sel0), .rd_en(rd_en0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .out_if(if0), .busy(busy0), .done(done0));
  fft_result_reader #(.N(N), .DATA_WIDTH(DW), .BITREV(1), .FIFO_DEPTH(FD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .finish(finish), .bank_sel(bank_sel1), .rd_en(rd_en1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_if(if1), .busy(busy1), .done(done1));
  fft_result_reader #(.N(16), .DATA_WIDTH(DW), .BITREV(0), .FIFO_DEPTH(FD)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .finish(1'b0), .bank_sel(bs16), .rd_en(rden16),
    .rd_addr(addr16), .rd_data(32'd0), .out_if(if16), .busy(busy16), .done(done16));
  fft_result_reader #(.N(4), .DATA_WIDTH(DW), .BITREV(0), .FIFO_DEPTH(FD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .finish(1'b0), .bank_sel(bs4), .rd_en(rden4),
    .rd_addr(addr4), .rd_data(32'd0), .out_if(if4), .busy(busy4), .done(done4));

  always @(posedge clk) begin
    if (rd_en0) rd_data0 <= ram[rd_addr0];
    if (rd_en1) rd_data1 <= ram[rd_addr1];
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Observation log, filled at the falling edge.
  typedef struct {int dut; int cyc; logic [15:0] re; logic [15:0] im; logic [2:0] idx; logic last;} hs_t;
  typedef struct {int dut; int cyc; logic [2:0] addr;} rd_t;
  typedef struct {int dut; int cyc;} ev_t;
  hs_t  hs_q[$];
  rd_t  rd_q[$];
  ev_t  done_q[$];
  int   issued [2], accepted [2];
  int   max_out = 0, stall_bad = 0;
  logic prev_stall [2];
  logic [35:0] prev_val [2];

  initial begin
    issued = '{0, 0}; accepted = '{0, 0}; prev_stall = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        issued = '{0, 0}; accepted = '{0, 0}; prev_stall = '{1'b0, 1'b0};
      end else begin
        for (int d = 0; d < 2; d++) begin
          logic v, en, dn;
          logic [2:0]  a;
          logic [35:0] cur;
          v   = (d == 0) ? if0.out_valid : if1.out_valid;
          en  = (d == 0) ? rd_en0 : rd_en1;
          a   = (d == 0) ? rd_addr0 : rd_addr1;
          dn  = (d == 0) ? done0 : done1;
          cur = (d == 0) ? {if0.out_re, if0.out_im, if0.out_index, if0.out_last}
                         : {if1.out_re, if1.out_im, if1.out_index, if1.out_last};
          if (prev_stall[d] && (!v || cur != prev_val[d])) stall_bad++;
          prev_stall[d] = v && !out_ready;
          prev_val[d]   = cur;
          if (en) begin rd_q.push_back('{d, cyc, a}); issued[d]++; end
          if (v && out_ready) begin
            hs_q.push_back('{d, cyc, cur[35:20], cur[19:4], cur[3:1], cur[0]});
            accepted[d]++;
          end
          if (issued[d] - accepted[d] > max_out) max_out = issued[d] - accepted[d];
          if (dn) done_q.push_back('{d, cyc});
        end
      end
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       begin out_ready = 1'b1; ph = 0; end
        1:       begin out_ready = (ph == 0 || ph == 3); ph = (ph + 1) % 4; end
        default: out_ready = ($urandom_range(0, 9) < 6);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_finish(output int c);
    c = cyc;
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((busy0 || busy1) && t < 300) begin tick(); t++; end
    chk({tag, "_end_bound"}, 64'(t < 300), 64'd1);
    repeat (3) tick();
  endtask

  task automatic load_ram(input bit rnd);
    for (int k = 0; k < N; k++) ram[k] = rnd ? $urandom : {16'(k), 16'(-k)};
  endtask

  // Reference: bin k carries RAM word at k (or its bit-reverse), in order, last at k=N-1.
  task automatic check_pass(input int c, input int lo, input int hi, input bit timed, input string tag);
    for (int d = 0; d < 2; d++) begin
      int n, na, nd;
      n = 0; na = 0; nd = 0;
      foreach (hs_q[i]) if (hs_q[i].dut == d && hs_q[i].cyc >= lo && hs_q[i].cyc < hi) begin
        if (n < N) begin
          logic [31:0] w;
          w = ram[(d != 0) ? br_tab[n] : n];
          chk($sformatf("%s_d%0d_idx%0d", tag, d, n), 64'(hs_q[i].idx), 64'(n));
          chk($sformatf("%s_d%0d_re%0d", tag, d, n), 64'(hs_q[i].re), 64'(w[31:16]));
          chk($sformatf("%s_d%0d_im%0d", tag, d, n), 64'(hs_q[i].im), 64'(w[15:0]));
          chk($sformatf("%s_d%0d_last%0d", tag, d, n), 64'(hs_q[i].last), 64'(n == N - 1));
          if (timed) chk($sformatf("%s_d%0d_cyc%0d", tag, d, n), 64'(hs_q[i].cyc - c), 64'(3 + n));
        end
        n++;
      end
      chk($sformatf("%s_d%0d_nbins", tag, d), 64'(n), 64'(N));
      foreach (rd_q[i]) if (rd_q[i].dut == d && rd_q[i].cyc >= lo && rd_q[i].cyc < hi) begin
        if (na < N)
          chk($sformatf("%s_d%0d_addr%0d", tag, d, na), 64'(rd_q[i].addr),
              64'((d != 0) ? br_tab[na] : na));
        na++;
      end
      chk($sformatf("%s_d%0d_nreads", tag, d), 64'(na), 64'(N));
      foreach (done_q[i]) if (done_q[i].dut == d && done_q[i].cyc >= lo && done_q[i].cyc < hi) begin
        if (timed) chk($sformatf("%s_d%0d_done_cyc", tag, d), 64'(done_q[i].cyc - c), 64'(N + 3));
        nd++;
      end
      chk($sformatf("%s_d%0d_ndone", tag, d), 64'(nd), 64'd1);
    end
  endtask

  initial begin
    int c, c2, tmp, cnt;
    load_ram(1'b0);
    repeat (3) tick();
    chk("rst_dut0", 64'({if0.out_valid, if0.out_re, if0.out_im, if0.out_index, if0.out_last,
                         rd_en0, rd_addr0, busy0, done0}), 64'd0);
    chk("rst_dut1", 64'({if1.out_valid, if1.out_re, if1.out_im, if1.out_index, if1.out_last,
                         rd_en1, rd_addr1, busy1, done1}), 64'd0);
    chk("rst_n16", 64'({if16.out_valid, if16.out_re, if16.out_im, if16.out_index, if16.out_last,
                        rden16, addr16, busy16, done16}), 64'd0);
    chk("rst_n4", 64'({if4.out_valid, if4.out_re, if4.out_im, if4.out_index, if4.out_last,
                       rden4, addr4, busy4, done4}), 64'd0);
    chk("bank_sel_n8", 64'({bank_sel0, bank_sel1}), 64'b11);
    chk("bank_sel_n16", 64'(bs16), 64'd0);
    chk("bank_sel_n4", 64'(bs4), 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full-rate pass, then a new finish in the very cycle done pulses.
    rdy_mode = 0;
    pulse_finish(c);
    chk("busy_c1", 64'({busy0, busy1, rd_en0, rd_en1}), 64'hF);
    while (cyc < c + N + 3) tick();
    chk("done_at_c11", 64'({done0, done1}), 64'b11);
    pulse_finish(c2);
    wait_idle("b2b");
    check_pass(c, c, c2 + 1, 1'b1, "full");
    check_pass(c2, c2 + 1, cyc + 1, 1'b1, "b2b");

    // Backpressure 1,0,0,1.
    load_ram(1'b1);
    rdy_mode = 1;
    pulse_finish(c);
    wait_idle("bp");
    check_pass(c, c, cyc + 1, 1'b0, "bp");

    // Finish while busy is ignored.
    rdy_mode = 0;
    load_ram(1'b1);
    pulse_finish(c);
    while (cyc < c + 5) tick();
    pulse_finish(tmp);
    wait_idle("ign");
    check_pass(c, c, cyc + 1, 1'b1, "ign");

    // Reset mid-pass after three bins.
    pulse_finish(c);
    while (cyc < c + 6) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", 64'({if0.out_valid, if0.out_re, if0.out_im, if0.out_index, if0.out_last,
                           rd_en0, rd_addr0, busy0, done0}), 64'd0);
    chk("abort_outs1", 64'({if1.out_valid, if1.out_re, if1.out_last, rd_en1, rd_addr1,
                            busy1, done1}), 64'd0);
    cnt = 0;
    foreach (hs_q[i]) if (hs_q[i].dut == 0 && hs_q[i].cyc >= c) cnt++;
    chk("abort_delivered", 64'(cnt), 64'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick();
    cnt = 0;
    foreach (done_q[i]) if (done_q[i].cyc >= c) cnt++;
    chk("abort_no_done", 64'(cnt), 64'd0);
    pulse_finish(c);
    wait_idle("restart");
    check_pass(c, c, cyc + 1, 1'b1, "restart");

    // Randomized data and random backpressure.
    for (int p = 0; p < 5; p++) begin
      load_ram(1'b1);
      rdy_mode = 2;
      pulse_finish(c);
      wait_idle($sformatf("rnd%0d", p));
      check_pass(c, c, cyc + 1, 1'b0, $sformatf("rnd%0d", p));
    end

    chk("stall_stable", 64'(stall_bad), 64'd0);
    chk("credit_le_depth", 64'(max_out <= FD), 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
